// File: rtl/call_stack_pkg.sv
// Shared constants and types for the return-address call stack.
// Holds default geometry, the PC-source encoding that selects the stack,
// and the per-cycle stack operation type.
package call_stack_pkg;

  localparam int DEPTH_DEFAULT = 8;
  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'd0,
    PC_SRC_BRANCH = 2'd1,
    PC_SRC_JUMP   = 2'd2,
    PC_SRC_STACK  = 2'd3
  } pc_src_t;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } stack_op_t;

endpackage

// File: rtl/call_stack_if.sv
// Handshake bundle between the fetch stage (master) and the call stack (slave).
interface call_stack_if
  import call_stack_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) ();

  logic                       EN;
  logic                       push;
  logic                       pop;
  logic [WIDTH-1:0]           pushData;
  logic [WIDTH-1:0]           topStack;
  logic                       empty;
  logic                       full;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output EN, push, pop, pushData,
    input  topStack, empty, full, count, overflow, underflow
  );

  modport slave (
    input  EN, push, pop, pushData,
    output topStack, empty, full, count, overflow, underflow
  );

endinterface

// File: rtl/call_stack_mem.sv
// Return-address storage: DEPTH x WIDTH array, one synchronous write port
// and one asynchronous read port so the top entry is visible combinationally.
module call_stack_mem
  import call_stack_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry on the clock edge; contents are never cleared.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// Hardware call stack for return addresses (pointer, count and sticky flags).
// Optional feature macro: CALL_STACK_WRAP_EN -- when defined, a push while full
// overwrites the oldest entry circularly; when undefined, such a push is dropped.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  call_stack_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

`ifdef CALL_STACK_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic [AW-1:0]    wp;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_addr;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             is_empty;
  logic             is_full;
  logic             wr_en;
  logic             mem_we;
  logic [WIDTH-1:0] rd_data;
  stack_op_t        op;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign top_idx  = wp - 1'b1;

  // Decode this cycle's operation; push+pop on an empty stack degrades to a push.
  always_comb begin
    op = OP_IDLE;
    if (bus.EN) begin
      if (bus.push && (!bus.pop || is_empty)) begin
        op = OP_PUSH;
      end else if (bus.push && bus.pop) begin
        op = OP_REPLACE;
      end else if (bus.pop && !is_empty) begin
        op = OP_POP;
      end
    end
  end

  // Select the write slot: next free slot for a push, current top for a replace.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wp;
    case (op)
      OP_PUSH:    wr_en = !is_full || WRAP_EN;
      OP_REPLACE: begin
        wr_en   = 1'b1;
        wr_addr = top_idx;
      end
      default:    wr_en = 1'b0;
    endcase
  end

  assign mem_we = wr_en && !reset;

  // Pointer, occupancy and sticky error flags; reset wins over every request.
  always_ff @(posedge clock) begin
    if (reset) begin
      wp          <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      case (op)
        OP_PUSH: begin
          if (!is_full) begin
            wp      <= wp + 1'b1;
            count_q <= count_q + 1'b1;
          end else begin
            overflow_q <= 1'b1;
            if (WRAP_EN) begin
              wp <= wp + 1'b1;
            end
          end
        end
        OP_POP: begin
          wp      <= wp - 1'b1;
          count_q <= count_q - 1'b1;
        end
        default: begin
        end
      endcase
      if (bus.EN && bus.pop && is_empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  call_stack_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (wr_addr),
    .wdata (bus.pushData),
    .raddr (top_idx),
    .rdata (rd_data)
  );

  assign bus.topStack  = is_empty ? '0 : rd_data;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_call_stack.sv
// Directed, table-driven bench for call_stack (DEPTH=8, WIDTH=32).
// Expected full-stack pop order follows CALL_STACK_WRAP_EN when it is defined.
module tb_call_stack;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  call_stack_if #(.DEPTH(8), .WIDTH(32)) bus ();

  call_stack #(
    .DEPTH (8),
    .WIDTH (32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        rst;
    logic        en;
    logic        push;
    logic        pop;
    logic [31:0] data;
    int          expCount;
    logic [31:0] expTop;
    logic        expEmpty;
    logic        expFull;
    logic        expOvf;
    logic        expUnf;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(logic rst, logic en, logic push, logic pop,
                              logic [31:0] data, int c, logic [31:0] top,
                              logic e, logic f, logic o, logic u);
    vec_t v;
    v.rst = rst; v.en = en; v.push = push; v.pop = pop; v.data = data;
    v.expCount = c; v.expTop = top; v.expEmpty = e; v.expFull = f;
    v.expOvf = o; v.expUnf = u;
    return v;
  endfunction

  task automatic checkField(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int c, input logic [31:0] top,
                             input logic e, input logic f, input logic o, input logic u);
    checkField({tag, ".count"},     32'(bus.count),     32'(c));
    checkField({tag, ".topStack"},  bus.topStack,       top);
    checkField({tag, ".empty"},     32'(bus.empty),     32'(e));
    checkField({tag, ".full"},      32'(bus.full),      32'(f));
    checkField({tag, ".overflow"},  32'(bus.overflow),  32'(o));
    checkField({tag, ".underflow"}, 32'(bus.underflow), 32'(u));
  endtask

  // Drive one cycle of inputs on the falling edge, then sample just after the rising edge.
  task automatic applyStimulus(input logic rst, input logic en, input logic push,
                               input logic pop, input logic [31:0] data);
    @(negedge clock);
    reset        = rst;
    bus.EN       = en;
    bus.push     = push;
    bus.pop      = pop;
    bus.pushData = data;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] expPop;
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.EN       = 1'b0;
    bus.push     = 1'b0;
    bus.pop      = 1'b0;
    bus.pushData = '0;

    //               rst en  ps  pp  data   cnt top    e  f  o  u
    vecs[0]  = mk(1, 0, 0, 0, 32'h0,  0, 32'h0,  1, 0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 32'h0,  0, 32'h0,  1, 0, 0, 0);
    vecs[2]  = mk(0, 1, 1, 0, 32'h10, 1, 32'h10, 0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 1, 0, 32'h20, 2, 32'h20, 0, 0, 0, 0);
    vecs[4]  = mk(0, 1, 1, 0, 32'h30, 3, 32'h30, 0, 0, 0, 0);
    vecs[5]  = mk(0, 1, 0, 1, 32'h0,  2, 32'h20, 0, 0, 0, 0);
    vecs[6]  = mk(0, 1, 0, 1, 32'h0,  1, 32'h10, 0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 0, 1, 32'h0,  0, 32'h0,  1, 0, 0, 0);
    vecs[8]  = mk(0, 1, 1, 0, 32'h40, 1, 32'h40, 0, 0, 0, 0);
    vecs[9]  = mk(0, 1, 1, 1, 32'h55, 1, 32'h55, 0, 0, 0, 0);
    vecs[10] = mk(0, 1, 0, 1, 32'h0,  0, 32'h0,  1, 0, 0, 0);
    vecs[11] = mk(0, 1, 0, 1, 32'h0,  0, 32'h0,  1, 0, 0, 1);
    vecs[12] = mk(0, 1, 1, 0, 32'h7,  1, 32'h7,  0, 0, 0, 1);
    vecs[13] = mk(0, 0, 1, 0, 32'hAA, 1, 32'h7,  0, 0, 0, 1);
    vecs[14] = mk(0, 0, 0, 1, 32'h0,  1, 32'h7,  0, 0, 0, 1);
    vecs[15] = mk(1, 1, 1, 0, 32'hBB, 0, 32'h0,  1, 0, 0, 0);
    vecs[16] = mk(0, 1, 1, 1, 32'h99, 1, 32'h99, 0, 0, 0, 1);
    vecs[17] = mk(1, 0, 0, 0, 32'h0,  0, 32'h0,  1, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].push, vecs[i].pop, vecs[i].data);
      checkOutput($sformatf("vec%0d", i), vecs[i].expCount, vecs[i].expTop,
                  vecs[i].expEmpty, vecs[i].expFull, vecs[i].expOvf, vecs[i].expUnf);
    end

    // Fill to capacity with 1..8, then one push past full.
    for (int v = 1; v <= 8; v++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'(v));
    end
    checkOutput("fill8", 8, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h9);
`ifdef CALL_STACK_WRAP_EN
    checkOutput("push9", 8, 32'h9, 1'b0, 1'b1, 1'b1, 1'b0);
`else
    checkOutput("push9", 8, 32'h8, 1'b0, 1'b1, 1'b1, 1'b0);
`endif

    // Drain: each top must be read before the pop that retires it.
    for (int k = 0; k < 8; k++) begin
`ifdef CALL_STACK_WRAP_EN
      expPop = 32'(9 - k);
`else
      expPop = 32'(8 - k);
`endif
      checkField($sformatf("drain%0d.topStack", k), bus.topStack, expPop);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    end
    checkOutput("drained", 0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a push burst discards everything.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'hA1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'hA2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'hA3);
    checkOutput("burst2", 2, 32'hA3, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'hA4);
    checkOutput("midreset", 0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h5);
    checkOutput("postreset.push", 1, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0);

    // Replace while occupied leaves the older entry underneath intact.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h6);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h66);
    checkOutput("replace", 2, 32'h66, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    checkOutput("replace.pop", 1, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/call_stack.md
CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 Parameter DEPTH, default 8, meaning number of return-address entries (power of two, 2..64).
REQ-002 Parameter WIDTH, default 32, meaning return-address width.
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 EN  input  1  stage enable; when low, no state changes.
REQ-006 push  input  1  CALL: store pushData as the new top.
REQ-007 pop  input  1  RET: discard the current top.
REQ-008 pushData  input  WIDTH  return address to store (PC + 1 from the fetch stage).
REQ-009 topStack  output  WIDTH  current top entry, feeding the PC "top of stack" source.
REQ-010 empty  output  1  count == 0.
REQ-011 full  output  1  count == DEPTH.
REQ-012 count  output  $clog2(DEPTH+1)  number of valid entries.
REQ-013 overflow  output  1  sticky flag: a push occurred while full.
REQ-014 underflow  output  1  sticky flag: a pop occurred while empty.

Function
REQ-015 topStack SHALL be a combinational read of the entry at (wp-1) mod DEPTH, so the PC register loads the correct value on the same edge that the pop retires it.
REQ-016 topStack SHALL be 0 when empty=1.
REQ-017 A push with EN=1 and pop=0 SHALL write pushData at wp, advance wp by 1 modulo DEPTH, and increment count; the new value is visible on topStack the next cycle.
REQ-018 A pop with EN=1 and push=0 SHALL decrement wp modulo DEPTH and decrement count; memory contents SHALL be unchanged.
REQ-019 push and pop together with EN=1 and count>0 SHALL overwrite the top entry with pushData and leave wp and count unchanged.
REQ-020 push and pop together with count=0 SHALL be treated as a push, and underflow SHALL be set.
REQ-021 A pop while empty SHALL leave wp and count unchanged and SHALL set underflow.
REQ-022 A push while full SHALL set overflow; the remaining behaviour is defined under Configuration.
REQ-023 With EN=0, push and pop SHALL be ignored; topStack SHALL still track the stored top.
REQ-024 overflow and underflow SHALL be cleared only by reset.

Reset
REQ-025 reset=1 at posedge SHALL set wp=0, count=0, overflow=0 and underflow=0; it overrides EN, push and pop in that cycle.
REQ-026 Memory contents need not be cleared; topStack SHALL read 0 after reset because empty=1.
REQ-027 Reset asserted during a push/pop burst SHALL discard all entries; the first push after reset lands at wp=0.

Configuration
REQ-028 Macro CALL_STACK_WRAP_EN defined: a push while full SHALL write at wp, advance wp, keep count=DEPTH, and overwrite the oldest entry (circular behaviour).
REQ-029 Macro CALL_STACK_WRAP_EN undefined: a push while full SHALL be dropped, with wp, count and memory unchanged.
REQ-030 overflow SHALL be set in both configurations.

Structure
REQ-031 The shared constants file SHALL hold the default DEPTH, WIDTH, and the PC-source encoding that selects the stack (value 3).
REQ-032 Storage SHALL be a sub-module call_stack_mem: DEPTH x WIDTH array with one synchronous write port and one asynchronous read port.
REQ-033 Pointer, count and flag logic SHALL stay in call_stack.

Verification
REQ-034 Reset, then idle -> empty=1, count=0, topStack=0, overflow=0, underflow=0.
REQ-035 Push 0x10, 0x20, 0x30, then pop three times -> topStack reads 0x30, 0x20, 0x10 on consecutive cycles, and empty=1 after the third pop.
REQ-036 Push 0x40, then push 0x55 and pop in the same cycle -> count=1, topStack=0x55.
REQ-037 DEPTH=8: push 1..9 -> full=1 and overflow=1; with WRAP_EN, 8 pops yield 9..2; without it, 8 pops yield 8..1.
REQ-038 Pop while empty -> underflow=1, count=0; a subsequent push of 0x7 -> topStack=0x7 and underflow still 1.
REQ-039 EN=0 with push=1 and pushData=0xAA -> count unchanged; then reset mid-sequence -> count=0 on the next cycle.
